// File: rtl/fir_mc.sv
// fir_mc: multi-channel FIR filter with one shared, time-multiplexed MAC.
// Each channel keeps an N-deep circular sample history. Coefficients are
// runtime-loadable and shared by all channels.
// Optional build macro FIR_MC_SATURATE_EN: when defined, the shifted
// accumulator is clamped to the signed M-bit range instead of wrapping.
module fir_mc #(
    parameter int N    = 16,
    parameter int M    = 24,
    parameter int CW   = 24,
    parameter int FRAC = 23,
    parameter int C    = 2,
    localparam int CHW = (C > 1) ? $clog2(C) : 1,
    localparam int KW  = $clog2(N)
) (
    input  logic                 ck,
    input  logic                 rst,
    input  logic signed [M-1:0]  in,
    input  logic [CHW-1:0]       in_ch,
    input  logic                 input_ready,
    input  logic                 coef_we,
    input  logic [KW-1:0]        coef_addr,
    input  logic signed [CW-1:0] coef_data,
    output logic signed [M-1:0]  out,
    output logic [CHW-1:0]       out_ch,
    output logic                 output_ready,
    output logic                 busy,
    output logic                 overrun
);

    localparam int PW = M + CW;
    localparam int AW = M + CW + $clog2(N);
    localparam logic [KW:0] NP1 = (KW+1)'(N);

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                state, state_nx;
    logic [CHW-1:0]        ch;
    logic [KW-1:0]         k;
    logic [KW-1:0]         wptr [C];
    logic signed [M-1:0]   hist [C][N];
    logic signed [CW-1:0]  coef [N];
    logic signed [AW-1:0]  acc;

    logic                  ch_ok, accept, drop, coef_wr, last_tap;
    logic [KW-1:0]         cur_wp, rd_idx;
    logic signed [M-1:0]   tap_x;
    logic signed [CW-1:0]  tap_c;
    logic signed [PW-1:0]  prod;

    // Shift the accumulator down by the coefficient fraction and fit it to M bits.
    function automatic logic signed [M-1:0] fmt_out(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] s;
`ifdef FIR_MC_SATURATE_EN
        logic signed [AW-1:0] omax;
        logic signed [AW-1:0] omin;
        omax = {{(AW-M+1){1'b0}}, {(M-1){1'b1}}};
        omin = {{(AW-M+1){1'b1}}, {(M-1){1'b0}}};
        s = a >>> FRAC;
        if (s > omax)
            s = omax;
        else if (s < omin)
            s = omin;
        return s[M-1:0];
`else
        s = a >>> FRAC;
        return s[M-1:0];
`endif
    endfunction

    assign ch_ok    = (32'(in_ch) < C);
    assign accept   = (state == IDLE) && input_ready && ch_ok;
    assign drop     = input_ready && !accept;
    assign coef_wr  = coef_we && (state == IDLE) && !input_ready;
    assign last_tap = (k == KW'(N - 1));
    assign busy     = (state == MAC);

    assign cur_wp = wptr[ch];

    // Tap address x[n-k]: walk backwards from the newest sample, wrapping mod N.
    always_comb begin
        rd_idx = '0;
        if (cur_wp >= k)
            rd_idx = cur_wp - k;
        else
            rd_idx = KW'({1'b0, cur_wp} + NP1 - {1'b0, k});
    end

    assign tap_x = hist[ch][rd_idx];
    assign tap_c = coef[k];
    assign prod  = PW'(tap_x) * PW'(tap_c);

    // State register.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic: IDLE -> MAC on an accepted strobe, N taps, one DONE cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = MAC;
            MAC:     if (last_tap) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Control: channel latch, tap counter, write pointers and output register.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            ch           <= '0;
            k            <= '0;
            out          <= '0;
            out_ch       <= '0;
            output_ready <= 1'b0;
            overrun      <= 1'b0;
            for (int c = 0; c < C; c++)
                wptr[c] <= '0;
        end else begin
            output_ready <= 1'b0;
            overrun      <= drop;
            case (state)
                IDLE: begin
                    if (accept) begin
                        ch <= in_ch;
                        k  <= '0;
                    end
                end
                MAC: begin
                    k <= k + KW'(1);
                    if (last_tap)
                        wptr[ch] <= (wptr[ch] == KW'(N - 1)) ? '0 : wptr[ch] + KW'(1);
                end
                DONE: begin
                    out          <= fmt_out(acc);
                    out_ch       <= ch;
                    output_ready <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Sample histories: the accepted sample lands at its channel's write pointer.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < C; c++)
                for (int t = 0; t < N; t++)
                    hist[c][t] <= '0;
        end else if (accept) begin
            hist[in_ch][wptr[in_ch]] <= in;
        end
    end

    // Coefficient bank: writable only while idle and no strobe is present.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            for (int t = 0; t < N; t++)
                coef[t] <= '0;
        end else if (coef_wr) begin
            coef[coef_addr] <= coef_data;
        end
    end

    // Accumulator: cleared on accept, one product added per MAC cycle.
    always_ff @(posedge ck) begin
        if (accept)
            acc <= '0;
        else if (state == MAC)
            acc <= acc + AW'(prod);
    end

endmodule

// File: tb/tb_fir_mc.sv
// tb_fir_mc: directed bench for fir_mc with a sample-level reference model.
module tb_fir_mc;

    localparam int N    = 16;
    localparam int M    = 24;
    localparam int CW   = 24;
    localparam int FRAC = 23;
    localparam int C    = 2;
    localparam int CHW  = 1;
    localparam int KW   = 4;

    logic                 ck = 1'b0;
    logic                 rst;
    logic signed [M-1:0]  s_in;
    logic [CHW-1:0]       s_ch;
    logic                 s_rdy;
    logic                 c_we;
    logic [KW-1:0]        c_addr;
    logic signed [CW-1:0] c_data;
    logic signed [M-1:0]  d_out;
    logic [CHW-1:0]       d_och;
    logic                 d_ordy;
    logic                 d_busy;
    logic                 d_ovr;

    int n_tot  = 0;
    int n_pass = 0;
    int n_ordy = 0;
    int n_ovr  = 0;
    longint caps[$];

    fir_mc #(.N(N), .M(M), .CW(CW), .FRAC(FRAC), .C(C)) dut (
        .ck(ck), .rst(rst), .in(s_in), .in_ch(s_ch), .input_ready(s_rdy),
        .coef_we(c_we), .coef_addr(c_addr), .coef_data(c_data),
        .out(d_out), .out_ch(d_och), .output_ready(d_ordy),
        .busy(d_busy), .overrun(d_ovr)
    );

    always #5 ck = ~ck;

    task automatic check(input string nm, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_tot++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    longint m_coef [N];
    longint m_hist [C][$];     // newest sample first
    int     edge_n    = 0;
    int     free_edge = 0;
    int     acc_edge  = -1000;
    longint pend_val  = 0;
    int     pend_ch   = 0;
    logic   e_busy = 1'b0, e_ordy = 1'b0, e_ovr = 1'b0;
    longint e_out = 0;
    int     e_och = 0;

    function automatic longint fold(input longint a);
        longint s;
        logic [63:0] u;
        logic signed [M-1:0] t;
        s = a >>> FRAC;
`ifdef FIR_MC_SATURATE_EN
        if (s > (longint'(1) <<< (M-1)) - 1) return (longint'(1) <<< (M-1)) - 1;
        if (s < -(longint'(1) <<< (M-1)))    return -(longint'(1) <<< (M-1));
        return s;
`else
        u = s;
        t = u[M-1:0];
        return longint'(t);
`endif
    endfunction

    function automatic longint filt(input int ch);
        longint sum = 0;
        for (int j = 0; j < m_hist[ch].size(); j++)
            sum += m_coef[j] * m_hist[ch][j];
        return fold(sum);
    endfunction

    always @(posedge ck) begin
        if (!rst) begin
            for (int j = 0; j < N; j++) m_coef[j] = 0;
            for (int c = 0; c < C; c++) m_hist[c].delete();
            free_edge = 0;
            acc_edge  = -1000;
            e_busy = 1'b0; e_ordy = 1'b0; e_ovr = 1'b0;
            e_out = 0; e_och = 0;
        end else begin
            edge_n++;
            e_ovr = 1'b0;
            if (s_rdy) begin
                if (edge_n >= free_edge && int'(s_ch) < C) begin
                    m_hist[s_ch].push_front(longint'(s_in));
                    if (m_hist[s_ch].size() > N) void'(m_hist[s_ch].pop_back());
                    pend_val  = filt(int'(s_ch));
                    pend_ch   = int'(s_ch);
                    acc_edge  = edge_n;
                    free_edge = edge_n + N + 2;
                end else begin
                    e_ovr = 1'b1;
                end
            end else if (c_we && edge_n >= free_edge) begin
                m_coef[c_addr] = longint'(c_data);
            end
            e_busy = (edge_n >= acc_edge) && (edge_n <= acc_edge + N - 1);
            e_ordy = (edge_n == acc_edge + N + 1);
            if (e_ordy) begin
                e_out = pend_val;
                e_och = pend_ch;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge ck) begin
        if (!rst) begin
            check("rst_busy", d_busy, 0);
            check("rst_output_ready", d_ordy, 0);
            check("rst_overrun", d_ovr, 0);
            check("rst_out", d_out, 0);
            check("rst_out_ch", d_och, 0);
        end else begin
            check("busy", d_busy, e_busy);
            check("output_ready", d_ordy, e_ordy);
            check("overrun", d_ovr, e_ovr);
            check("out", d_out, e_out);
            check("out_ch", d_och, e_och);
            if (d_ordy) begin
                caps.push_back(longint'(d_out));
                n_ordy++;
            end
            if (d_ovr) n_ovr++;
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic signed [63:0] cap_at(input int j);
        if (j < caps.size()) return caps[j];
        return 'x;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge ck);
        #1;
    endtask

    task automatic wcoef(input int k, input longint v);
        c_we = 1'b1; c_addr = KW'(k); c_data = CW'(v);
        step(1);
        c_we = 1'b0;
    endtask

    task automatic load_ramp();
        for (int k = 0; k < N; k++) wcoef(k, longint'(k + 1) * 64'h10000);
    endtask

    task automatic load_flat(input longint v);
        for (int k = 0; k < N; k++) wcoef(k, v);
    endtask

    task automatic strobe(input int ch, input longint val, input int gap, input bit inj);
        s_ch = CHW'(ch); s_in = M'(val); s_rdy = 1'b1;
        if (inj) begin c_we = 1'b1; c_addr = '0; c_data = 24'sh7FFFFF; end
        step(1);
        s_rdy = 1'b0;
        if (inj) begin
            step(5);
            c_we = 1'b0;
            step(gap - 6);
        end else begin
            step(gap - 1);
        end
    endtask

    task automatic impulse(input bit inj);
        caps.delete();
        strobe(0, 2048, 25, inj);
        for (int j = 1; j < N; j++) strobe(0, 0, 25, 1'b0);
        check("impulse_count", caps.size(), N);
        for (int j = 0; j < N; j++) check("impulse_val", cap_at(j), 16 * (j + 1));
    endtask

    int ovr0, ordy0;

    initial begin
        rst = 1'b0; s_in = '0; s_ch = '0; s_rdy = 1'b0;
        c_we = 1'b0; c_addr = '0; c_data = '0;
        step(3);
        check("reset_out", d_out, 0);
        check("reset_busy", d_busy, 0);
        check("reset_ordy", d_ordy, 0);
        rst = 1'b1;
        step(2);

        // impulse response, then the impulse leaves the history
        load_ramp();
        impulse(1'b0);
        caps.delete();
        strobe(0, 0, 25, 1'b0);
        check("impulse_tail", cap_at(0), 0);

        // DC gain on ch1; ch0 untouched
        load_flat(64'h080000);
        caps.delete();
        for (int j = 0; j < N; j++) strobe(1, 10000, 20, 1'b0);
        check("dc_first", cap_at(0), 625);
        check("dc_last", cap_at(N - 1), 10000);
        caps.delete();
        strobe(0, 0, 20, 1'b0);
        check("dc_ch0_zero", cap_at(0), 0);

        // overrun: second strobe 3 cycles after the first is dropped
        caps.delete();
        ovr0 = n_ovr; ordy0 = n_ordy;
        s_ch = '0; s_in = 1000; s_rdy = 1'b1;
        step(1);
        s_rdy = 1'b0;
        step(2);
        s_in = 500; s_rdy = 1'b1;
        step(1);
        s_rdy = 1'b0;
        step(25);
        check("overrun_pulses", n_ovr - ovr0, 1);
        check("overrun_outputs", n_ordy - ordy0, 1);
        check("overrun_val", cap_at(0), 62);
        strobe(0, 0, 20, 1'b0);
        check("overrun_wptr", cap_at(1), 62);

        // coefficient writes during strobe and MAC are ignored
        load_ramp();
        for (int j = 0; j < N; j++) strobe(0, 0, 20, 1'b0);
        impulse(1'b1);

        // overflow
        load_flat(64'h7FFFFF);
        caps.delete();
        for (int j = 0; j < N; j++) strobe(0, 64'h7FFFFF, 20, 1'b0);
        check("ovf_first", cap_at(0), 8388606);
`ifdef FIR_MC_SATURATE_EN
        check("ovf_last", cap_at(N - 1), 8388607);
`else
        check("ovf_last", cap_at(N - 1), -32);
`endif

        // reset in the middle of a MAC
        load_ramp();
        s_ch = '0; s_in = 300; s_rdy = 1'b1;
        step(1);
        s_rdy = 1'b0;
        step(4);
        rst = 1'b0;
        #1;
        check("midrst_out", d_out, 0);
        check("midrst_busy", d_busy, 0);
        check("midrst_ordy", d_ordy, 0);
        step(3);
        rst = 1'b1;
        ordy0 = n_ordy;
        step(25);
        check("midrst_no_output", n_ordy - ordy0, 0);
        load_ramp();
        impulse(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
